// File: rtl/txuart_pkg.sv
// Shared UART timing helpers and FSM encodings, also used by rxuart so both
// ends derive identical bit timing from the same clock/baud parameters.
package txuart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_t;

    // Clocks per bit, rounded to nearest.
    function automatic int calc_clks_per_bit(input int clk_freq, input int baud_rate);
        return (clk_freq + baud_rate / 2) / baud_rate;
    endfunction

    function automatic int calc_timer_w(input int clks_per_bit);
        return (clks_per_bit < 2) ? 1 : $clog2(clks_per_bit);
    endfunction

endpackage

// File: rtl/uart_baud_timer.sv
// Bit-period timer: pulses o_tick on the last cycle of each bit period.
// Held at zero while i_run is low so every frame starts phase-aligned.
module uart_baud_timer
    import txuart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 217
) (
    input  logic i_clk,
    input  logic rst,
    input  logic i_run,
    output logic o_tick
);

    localparam int              W    = calc_timer_w(CLKS_PER_BIT);
    localparam logic [W-1:0]    LAST = W'(CLKS_PER_BIT - 1);

    logic [W-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (rst || !i_run) begin
            r_cnt <= '0;
        end else if (r_cnt == LAST) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_tick = i_run && (r_cnt == LAST);

endmodule

// File: rtl/txuart.sv
// UART transmitter: 8N1 (optionally 8E1) frame per accepted write, LSB first.
// Writes while busy are dropped; o_done pulses on the final stop-bit cycle.
module txuart
    import txuart_pkg::*;
#(
    parameter int clkFreq   = 25000000,
    parameter int baudRate  = 115200,
    parameter bit if_parity = 1'b0
) (
    input  logic       i_clk,
    input  logic       rst,
    input  logic       i_wr,
    input  logic [7:0] i_data,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_uart_tx
);

    localparam int CLKS_PER_BIT = calc_clks_per_bit(clkFreq, baudRate);

    generate
        if (CLKS_PER_BIT < 2) begin : g_bad_baud
            $error("txuart: clkFreq/baudRate gives fewer than 2 clocks per bit");
        end
    endgenerate

    uart_state_t r_state, w_state_nxt;
    logic [7:0]  r_shift, w_shift_nxt;
    logic [2:0]  r_bitcnt, w_bitcnt_nxt;
    logic        r_par, w_par_nxt;
    logic        r_tx, w_tx_nxt;
    logic        w_tick;
    logic        w_run;
    logic        w_done;

    assign w_run = (r_state != ST_IDLE);

    uart_baud_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_timer (
        .i_clk (i_clk),
        .rst   (rst),
        .i_run (w_run),
        .o_tick(w_tick)
    );

    always_ff @(posedge i_clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_shift  <= '0;
            r_bitcnt <= '0;
            r_par    <= 1'b0;
            r_tx     <= 1'b1;
        end else begin
            r_state  <= w_state_nxt;
            r_shift  <= w_shift_nxt;
            r_bitcnt <= w_bitcnt_nxt;
            r_par    <= w_par_nxt;
            r_tx     <= w_tx_nxt;
        end
    end

    // The line register is loaded with the level of the *next* bit on each
    // tick, so o_uart_tx only moves on bit boundaries.
    always_comb begin
        w_state_nxt  = r_state;
        w_shift_nxt  = r_shift;
        w_bitcnt_nxt = r_bitcnt;
        w_par_nxt    = r_par;
        w_tx_nxt     = r_tx;
        w_done       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_tx_nxt = 1'b1;
                if (i_wr) begin
                    w_shift_nxt  = i_data;
                    w_par_nxt    = ^i_data;
                    w_bitcnt_nxt = '0;
                    w_tx_nxt     = 1'b0;
                    w_state_nxt  = ST_START;
                end
            end
            ST_START: begin
                if (w_tick) begin
                    w_tx_nxt    = r_shift[0];
                    w_state_nxt = ST_DATA;
                end
            end
            ST_DATA: begin
                if (w_tick) begin
                    w_shift_nxt = {1'b0, r_shift[7:1]};
                    if (r_bitcnt == 3'd7) begin
                        if (if_parity) begin
                            w_tx_nxt    = r_par;
                            w_state_nxt = ST_PARITY;
                        end else begin
                            w_tx_nxt    = 1'b1;
                            w_state_nxt = ST_STOP;
                        end
                    end else begin
                        w_bitcnt_nxt = r_bitcnt + 3'd1;
                        w_tx_nxt     = r_shift[1];
                    end
                end
            end
            ST_PARITY: begin
                if (w_tick) begin
                    w_tx_nxt    = 1'b1;
                    w_state_nxt = ST_STOP;
                end
            end
            ST_STOP: begin
                if (w_tick) begin
                    w_done      = !rst;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_tx_nxt    = 1'b1;
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign o_busy    = w_run;
    assign o_done    = w_done;
    assign o_uart_tx = r_tx;

endmodule

// File: tb/tb_txuart.sv
// Scoreboard bench: two transmitters (no parity / even parity), stimulus pushes
// expected frames, per-DUT monitors check every line cycle against the model.
module tb_txuart;

    localparam int C        = 217;
    localparam int HIGH_GAP = 218;

    typedef struct {
        logic [7:0] dat;
        int         abort_len;
        int         gap;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst0, rst1, wr0, wr1;
    logic [7:0] dat0, dat1;
    logic [1:0] busy_v, done_v, tx_v;

    int   checks = 0;
    int   errors = 0;
    int   line_err [2];
    int   done_err [2];
    exp_t q0 [$];
    exp_t q1 [$];

    always #5 clk = ~clk;

    txuart u_dut0 (
        .i_clk(clk), .rst(rst0), .i_wr(wr0), .i_data(dat0),
        .o_busy(busy_v[0]), .o_done(done_v[0]), .o_uart_tx(tx_v[0])
    );

    txuart #(.if_parity(1'b1)) u_dut1 (
        .i_clk(clk), .rst(rst1), .i_wr(wr1), .i_data(dat1),
        .o_busy(busy_v[1]), .o_done(done_v[1]), .o_uart_tx(tx_v[1])
    );

    // Reference frame: start 0, D0..D7, optional even-parity bit, stop 1.
    task automatic build(input logic [7:0] b, input bit par,
                         output logic [10:0] bits, output int nb);
        int ones = 0;
        bits = '0;
        bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) begin
            bits[i+1] = b[i];
            ones += int'(b[i]);
        end
        if (par) begin
            bits[9]  = ((ones % 2) == 1);
            bits[10] = 1'b1;
            nb = 11;
        end else begin
            bits[9] = 1'b1;
            nb = 10;
        end
    endtask

    task automatic push(input int d, input exp_t e);
        if (d == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    task automatic pop(input int d, output bit ok, output exp_t e);
        ok = 1'b0;
        e  = '{dat: 8'h00, abort_len: 0, gap: -1};
        if (d == 0 && q0.size() > 0) begin e = q0.pop_front(); ok = 1'b1; end
        if (d == 1 && q1.size() > 0) begin e = q1.pop_front(); ok = 1'b1; end
    endtask

    task automatic set_wr(input int d, input logic v, input logic [7:0] b);
        if (d == 0) begin wr0 = v; dat0 = b; end
        else        begin wr1 = v; dat1 = b; end
    endtask

    task automatic set_rst(input int d, input logic v);
        if (d == 0) rst0 = v;
        else        rst1 = v;
    endtask

    task automatic wait_idle(input int d);
        int n = 0;
        while (busy_v[d] !== 1'b0 && n < 5000) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 5000) begin
            checks++; errors++;
            $display("FAIL idle_timeout dut%0d: busy=%b after %0d cycles, required 0", d, busy_v[d], n);
        end
    endtask

    task automatic send(input int d, input logic [7:0] b, input int abort_len, input int gap);
        exp_t e;
        wait_idle(d);
        e = '{dat: b, abort_len: abort_len, gap: gap};
        push(d, e);
        set_wr(d, 1'b1, b);
        @(posedge clk); #1;
        set_wr(d, 1'b0, b ^ 8'hA5);
    endtask

    task automatic pulse_ignored(input int d, input logic [7:0] b);
        set_wr(d, 1'b1, b);
        @(posedge clk); #1;
        set_wr(d, 1'b0, 8'h00);
    endtask

    task automatic monitor(input int d, input bit par);
        int         idle = 0;
        int         nb, len, at_k, n;
        exp_t       e;
        bit         ok, bad;
        logic [10:0] bits;
        logic       e_tx, e_done, a_tx, a_busy, a_done;
        forever begin
            @(negedge clk);
            if (busy_v[d] !== 1'b1) begin
                idle++;
                if (tx_v[d] !== 1'b1) line_err[d]++;
                if (done_v[d] !== 1'b0) done_err[d]++;
            end else begin
                pop(d, ok, e);
                if (!ok) begin
                    checks++; errors++;
                    $display("FAIL unexpected_frame dut%0d: busy=1 with no write outstanding, required busy=0", d);
                    n = 0;
                    while (busy_v[d] === 1'b1 && n < 5000) begin @(negedge clk); n++; end
                    idle = 0;
                end else begin
                    if (e.gap >= 0) begin
                        checks++;
                        if (idle + C != HIGH_GAP) begin
                            errors++;
                            $display("FAIL gap dut%0d byte %02h: line high %0d cycles, required %0d",
                                     d, e.dat, idle + C, HIGH_GAP);
                        end
                    end
                    build(e.dat, par, bits, nb);
                    len = (e.abort_len > 0) ? e.abort_len : nb * C;
                    bad = 1'b0;
                    at_k = 0; a_tx = 1'b0; a_busy = 1'b0; a_done = 1'b0; e_done = 1'b0;
                    for (int k = 0; k < len; k++) begin
                        if (k > 0) @(negedge clk);
                        e_tx   = bits[k / C];
                        e_done = (e.abort_len == 0) && (k == nb * C - 1);
                        if (!bad && (tx_v[d] !== e_tx || busy_v[d] !== 1'b1 || done_v[d] !== e_done)) begin
                            bad = 1'b1; at_k = k;
                            a_tx = tx_v[d]; a_busy = busy_v[d]; a_done = done_v[d];
                        end
                        if ((k % C) == C - 1 || k == len - 1) begin
                            checks++;
                            if (bad) begin
                                errors++;
                                $display("FAIL frame_bit dut%0d byte %02h bit %0d cycle %0d: tx=%b busy=%b done=%b, required tx=%b busy=1 done=%b",
                                         d, e.dat, k / C, at_k, a_tx, a_busy, a_done, bits[at_k / C],
                                         (e.abort_len == 0) && (at_k == nb * C - 1));
                            end
                            bad = 1'b0;
                        end
                    end
                    @(negedge clk);
                    checks++;
                    if (busy_v[d] !== 1'b0 || tx_v[d] !== 1'b1 || done_v[d] !== 1'b0) begin
                        errors++;
                        $display("FAIL frame_end dut%0d byte %02h: busy=%b tx=%b done=%b, required busy=0 tx=1 done=0",
                                 d, e.dat, busy_v[d], tx_v[d], done_v[d]);
                    end
                    idle = 1;
                end
            end
        end
    endtask

    task automatic check_reset(input int d);
        checks++;
        if (tx_v[d] !== 1'b1) begin errors++; $display("FAIL reset_tx dut%0d: %b, required 1", d, tx_v[d]); end
        checks++;
        if (busy_v[d] !== 1'b0) begin errors++; $display("FAIL reset_busy dut%0d: %b, required 0", d, busy_v[d]); end
        checks++;
        if (done_v[d] !== 1'b0) begin errors++; $display("FAIL reset_done dut%0d: %b, required 0", d, done_v[d]); end
    endtask

    initial begin
        repeat (90000) @(posedge clk);
        $display("FAIL watchdog: simulation exceeded cycle budget");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        line_err[0] = 0; line_err[1] = 0;
        done_err[0] = 0; done_err[1] = 0;
        rst0 = 1'b1; rst1 = 1'b1;
        wr0 = 1'b0; wr1 = 1'b0; dat0 = 8'h00; dat1 = 8'h00;
        fork
            monitor(0, 1'b0);
            monitor(1, 1'b1);
        join_none
        repeat (3) @(posedge clk);
        #1;
        check_reset(0);
        check_reset(1);
        rst0 = 1'b0; rst1 = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        fork
            begin
                send(0, 8'h41, 0, -1);
                // Write while busy must be dropped.
                wait_idle(0);
                repeat (300) @(posedge clk); #1;
                send(0, 8'h41, 0, -1);
                repeat (500) @(posedge clk); #1;
                pulse_ignored(0, 8'hFF);
                wait_idle(0);
                repeat (300) @(posedge clk); #1;
                // Reset during data bit 3 (line bit index 4).
                w = 4 * C + 100;
                send(0, 8'hC6, w + 1, -1);
                repeat (w) @(posedge clk);
                #1;
                set_rst(0, 1'b1);
                @(posedge clk); #1;
                set_rst(0, 1'b0);
                repeat (20) @(posedge clk); #1;
                send(0, 8'h55, 0, -1);
                send(0, 8'h41, 0, 1);
                send(0, 8'h42, 0, 1);
                send(0, 8'h43, 0, 1);
                send(0, 8'h44, 0, 1);
                for (int i = 0; i < 3; i++) begin
                    wait_idle(0);
                    repeat ($urandom_range(0, 40)) @(posedge clk);
                    #1;
                    send(0, 8'($urandom_range(0, 255)), 0, -1);
                end
                wait_idle(0);
            end
            begin
                send(1, 8'h43, 0, -1);
                send(1, 8'h03, 0, 1);
                for (int i = 0; i < 5; i++) begin
                    send(1, 8'($urandom_range(0, 255)), 0, 1);
                end
                wait_idle(1);
            end
        join

        repeat (400) @(posedge clk);
        #1;
        checks++;
        if (q0.size() != 0) begin errors++; $display("FAIL frames_seen dut0: %0d outstanding, required 0", q0.size()); end
        checks++;
        if (q1.size() != 0) begin errors++; $display("FAIL frames_seen dut1: %0d outstanding, required 0", q1.size()); end
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (line_err[d] != 0) begin errors++; $display("FAIL idle_line dut%0d: %0d low idle cycles, required 0", d, line_err[d]); end
            checks++;
            if (done_err[d] != 0) begin errors++; $display("FAIL stray_done dut%0d: %0d idle done pulses, required 0", d, done_err[d]); end
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
